// File: rtl/pixel_pkg.sv
// Shared pixel-pipeline definitions: frame geometry defaults,
// capture FSM states and a counter-width helper.
package pixel_pkg;

    localparam int unsigned ROWS_DEF   = 200;
    localparam int unsigned COLS_DEF   = 300;
    localparam int unsigned WORD_W_DEF = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } cap_state_e;

    // Width of a counter over n values; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster write-position tracker: word/row counting with wrap,
// restart on start-of-frame and a last-beat flag.
module raster_counter
    import pixel_pkg::*;
#(
    parameter int unsigned ROWS = ROWS_DEF,
    parameter int unsigned WPR  = COLS_DEF / WORD_W_DEF,
    localparam int unsigned RW  = cnt_w(ROWS),
    localparam int unsigned WW  = cnt_w(WPR)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv_i,
    input  logic          sof_i,
    output logic [RW-1:0] row_o,
    output logic [WW-1:0] word_o,
    output logic          last_o
);

    localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
    localparam logic [WW-1:0] WORD_MAX = WW'(WPR - 1);

    logic [RW-1:0] row_q, row_d;
    logic [WW-1:0] word_q, word_d;

    // A start-of-frame beat always lands at the origin.
    always_comb begin
        row_o  = sof_i ? '0 : row_q;
        word_o = sof_i ? '0 : word_q;
        last_o = (row_o == ROW_MAX) && (word_o == WORD_MAX);
        row_d  = row_q;
        word_d = word_q;
        if (adv_i) begin
            if (word_o == WORD_MAX) begin
                word_d = '0;
                row_d  = (row_o == ROW_MAX) ? '0 : row_o + 1'b1;
            end else begin
                word_d = word_o + 1'b1;
                row_d  = row_o;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            word_q <= '0;
        end else begin
            row_q  <= row_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/pixel_frame_capture.sv
// Assembles a binary frame from a word stream and holds it until
// the consumer acknowledges; flags framing violations.
module pixel_frame_capture
    import pixel_pkg::*;
#(
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned WORD_W = WORD_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WORD_W-1:0]          s_data,
    input  logic                       s_sof,
    output logic [ROWS-1:0][COLS-1:0]  image,
    output logic                       frame_valid,
    output logic                       frame_done,
    input  logic                       frame_ack,
    output logic                       sync_err
);

    localparam int unsigned WPR = COLS / WORD_W;
    localparam int unsigned RW  = cnt_w(ROWS);
    localparam int unsigned WW  = cnt_w(WPR);
    localparam int unsigned CBW = cnt_w(COLS);

    cap_state_e state_q, state_d;
    logic       frame_done_q, frame_done_d;
    logic       sync_err_q, sync_err_d;

    logic [ROWS-1:0][COLS-1:0] image_q;

    logic           accept;
    logic           adv;
    logic           last;
    logic [RW-1:0]  wr_row;
    logic [WW-1:0]  wr_word;
    logic [CBW-1:0] col_base;

    assign s_ready = (state_q != HOLD);
    assign accept  = s_valid & s_ready;
    // Beats without sof are only stored once a frame is underway.
    assign adv     = accept & (s_sof | (state_q == CAPTURE));

    raster_counter #(
        .ROWS (ROWS),
        .WPR  (WPR)
    ) u_raster (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv_i  (adv),
        .sof_i  (accept & s_sof),
        .row_o  (wr_row),
        .word_o (wr_word),
        .last_o (last)
    );

    assign col_base = CBW'(wr_word) * CBW'(WORD_W);

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!s_sof) begin
                        sync_err_d = 1'b1;
                    end else if (last) begin
                        state_d      = HOLD;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (accept) begin
                    sync_err_d = s_sof;
                    if (last) begin
                        state_d      = HOLD;
                        frame_done_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            image_q <= '0;
        end else if (adv) begin
            image_q[wr_row][col_base +: WORD_W] <= s_data;
        end
    end

    assign image       = image_q;
    assign frame_valid = (state_q == HOLD);
    assign frame_done  = frame_done_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_pixel_frame_capture.sv
// Randomized frame-capture bench with a beat-count reference model.
module tb_pixel_frame_capture;
    import pixel_pkg::*;

    localparam int R   = ROWS_DEF;
    localparam int C   = COLS_DEF;
    localparam int W   = WORD_W_DEF;
    localparam int WPR = C / W;
    localparam int NB  = R * WPR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_sof = 1'b0;
    logic frame_ack = 1'b0;
    logic [W-1:0] s_data = '0;
    logic s_ready, frame_valid, frame_done, sync_err;
    logic [R-1:0][C-1:0] image;

    pixel_frame_capture #(
        .ROWS   (R),
        .COLS   (C),
        .WORD_W (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .image       (image),
        .frame_valid (frame_valid),
        .frame_done  (frame_done),
        .frame_ack   (frame_ack),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_done = 0;
    int n_err = 0;

    // Reference: frame in progress, frame held, beats since sof.
    logic [R-1:0][C-1:0] m_img = '0;
    bit m_cap = 0;
    bit m_hold = 0;
    int m_beat = 0;

    task automatic step(input bit v, input bit sof,
                        input logic [W-1:0] d, input bit ack);
        bit exp_rdy, acc, e_done, e_err;
        int r, wd;
        exp_rdy = !m_hold;
        checks++;
        if (s_ready !== exp_rdy) begin
            failures++;
            $display("FAIL s_ready cyc=%0d act=%b req=%b", cyc, s_ready, exp_rdy);
        end
        e_done = 0;
        e_err = 0;
        acc = v && exp_rdy;
        if (m_hold) begin
            if (ack) m_hold = 0;
        end else if (acc) begin
            if (sof) begin
                if (m_cap) e_err = 1;
                m_cap = 1;
                m_beat = 0;
            end else if (!m_cap) begin
                e_err = 1;
            end
            if (m_cap) begin
                r = m_beat / WPR;
                wd = m_beat % WPR;
                for (int k = 0; k < W; k++) m_img[r][wd*W+k] = d[k];
                m_beat++;
                if (m_beat == NB) begin
                    e_done = 1;
                    m_hold = 1;
                    m_cap = 0;
                    m_beat = 0;
                end
            end
        end
        s_valid = v;
        s_sof = sof;
        s_data = d;
        frame_ack = ack;
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (frame_done !== e_done) begin
            failures++;
            $display("FAIL frame_done cyc=%0d act=%b req=%b", cyc, frame_done, e_done);
        end
        checks++;
        if (sync_err !== e_err) begin
            failures++;
            $display("FAIL sync_err cyc=%0d act=%b req=%b", cyc, sync_err, e_err);
        end
        checks++;
        if (frame_valid !== m_hold) begin
            failures++;
            $display("FAIL frame_valid cyc=%0d act=%b req=%b", cyc, frame_valid, m_hold);
        end
        if (frame_done === 1'b1) n_done++;
        if (sync_err === 1'b1) n_err++;
    endtask

    task automatic check_image(input string nm);
        int bad;
        bad = -1;
        checks++;
        for (int r = 0; r < R; r++)
            if (bad < 0 && image[r] !== m_img[r]) bad = r;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s row=%0d act=%h req=%h", nm, bad, image[bad], m_img[bad]);
        end
    endtask

    task automatic check_count(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s act=%0d req=%0d", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] checker_word(input int b);
        logic [W-1:0] w;
        int r, c0;
        r = b / WPR;
        c0 = (b % WPR) * W;
        for (int k = 0; k < W; k++) w[k] = 1'((r + c0 + k) % 2);
        return w;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return W'($urandom);
    endfunction

    // Sends one whole frame (sof on first accepted beat) until held.
    task automatic run_frame(input bit gaps, input bit chk);
        int b, guard;
        bit v;
        logic [W-1:0] d;
        b = 0;
        guard = 0;
        while (!m_hold && guard < 20 * NB) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            d = chk ? checker_word(b) : rand_word();
            step(v, b == 0, d, 1'b0);
            if (v) b++;
            guard++;
        end
        checks++;
        if (!m_hold) begin
            failures++;
            $display("FAIL frame_timeout act=%0d req=%0d", b, NB);
        end
    endtask

    task automatic release_frame();
        step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (frame_valid !== 1'b0 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs act=%b%b%b req=000", frame_valid, frame_done, sync_err);
        end
        check_image("reset_image");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        int d0;
        d0 = n_done;
        run_frame(1'b0, 1'b1);
        check_count("full_done_pulses", n_done - d0, 1);
        check_image("full_image");
    endtask

    task automatic test_hold_ack();
        int d0;
        d0 = n_done;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, rand_word(), 1'b0);
            check_image("hold_freeze");
        end
        step(1'b1, 1'b1, rand_word(), 1'b1);
        check_image("hold_ack_edge");
        check_count("hold_done_pulses", n_done - d0, 0);
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_gaps();
        int d0;
        d0 = n_done;
        run_frame(1'b1, 1'b0);
        check_count("gaps_done_pulses", n_done - d0, 1);
        check_image("gaps_image");
        release_frame();
    endtask

    task automatic test_no_sof();
        int e0, d0;
        e0 = n_err;
        d0 = n_done;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_word(), 1'b0);
        run_frame(1'b0, 1'b0);
        check_count("nosof_err_pulses", n_err - e0, 3);
        check_count("nosof_done_pulses", n_done - d0, 1);
        check_image("nosof_image");
        release_frame();
    endtask

    task automatic test_restart();
        int e0, d0;
        e0 = n_err;
        d0 = n_done;
        for (int b = 0; b < 699; b++) step(1'b1, b == 0, rand_word(), 1'b0);
        step(1'b1, 1'b1, rand_word(), 1'b0);
        for (int b = 1; b < 2000; b++) begin
            step(1'b1, 1'b0, rand_word(), 1'b0);
            if (b == 1998) check_count("restart_early_done", n_done - d0, 0);
        end
        check_count("restart_err_pulses", n_err - e0, 1);
        check_count("restart_done_pulses", n_done - d0, 1);
        check_image("restart_image");
        release_frame();
    endtask

    task automatic test_reset_mid();
        int e0;
        for (int b = 0; b < 1000; b++) step(1'b1, b == 0, rand_word(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        m_cap = 0;
        m_hold = 0;
        m_beat = 0;
        m_img = '0;
        checks++;
        if (frame_valid !== 1'b0 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs act=%b%b%b req=000", frame_valid, frame_done, sync_err);
        end
        check_image("midreset_image");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        e0 = n_err;
        step(1'b1, 1'b0, rand_word(), 1'b0);
        check_count("midreset_needs_sof", n_err - e0, 1);
        run_frame(1'b0, 1'b1);
        check_image("midreset_frame");
        release_frame();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_hold_ack();
        test_gaps();
        test_no_sof();
        test_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
